shiftregister_universal: RTL and testbench
==========================================

# shiftregister_universal

Parametrised universal shift register, the successor to the fixed 5-bit right-only shifter in the lab's sequential-circuit experiments. It supports hold, right and left shift, and synchronous parallel load. A burst controller performs a programmed number of shifts autonomously and reports completion. Optional rotate modes are compiled in with a macro. The block drives the LED/serial-output stages of the experiment boards and replaces per-bit flip-flop chains.

## Interface
- WIDTH, 8: register width in bits; minimum 2.
- CNT_W, 4: width of the burst shift-count input.

- clockpulse  input  1  clock; all state changes on rising edge.
- clear  input  1  asynchronous, active-high reset.
- mode  input  3  operation select:
  - 000 hold
  - 001 shift right
  - 010 shift left
  - 011 parallel load
  - 100 rotate right
  - 101 rotate left
  - 110/111 hold
- serialRight  input  1  bit entering out[WIDTH-1] on shift right.
- serialLeft  input  1  bit entering out[0] on shift left.
- preset  input  WIDTH  parallel-load data.
- start  input  1  request a burst of shiftCount shifts in the current mode.
- shiftCount  input  CNT_W  number of shifts in a burst.
- out  output  WIDTH  register contents.
- notout  output  WIDTH  bitwise complement of out, always.
- serialOut  output  1  out[0] in right modes, out[WIDTH-1] in left modes; out[0] otherwise.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse on burst completion.

## Operation
- States: IDLE, BUSY.
- IDLE, start=0: the edge applies mode directly:
  - shift right: out <= {serialRight, out[WIDTH-1:1]}
  - shift left: out <= {out[WIDTH-2:0], serialLeft}
  - load: out <= preset
  - rotate right/left: circular shift with no serial input
  - hold: no change
- IDLE, start=1, mode is a shift or rotate code:
  - the edge latches mode into burstMode and shiftCount into remaining; no shift on this edge.
  - busy=1 from the next cycle if shiftCount != 0.
- IDLE, start=1, shiftCount=0: no shift, stay IDLE, done=1 for the following cycle.
- IDLE, start=1, mode is hold/load/unused: start is ignored and mode is applied normally.
- BUSY:
  - each edge performs one shift in burstMode and decrements remaining.
  - on the edge where remaining goes 1->0: return to IDLE, busy=0, done=1 for exactly that cycle.
- During BUSY, mode, start, shiftCount and preset are ignored.
- During BUSY, serialRight/serialLeft are sampled live on every edge.
- shiftCount > WIDTH is legal: the burst shifts that many times, filling entirely with serial input.
- done and start in the same cycle (IDLE): the new burst is accepted normally.

## Timing
- Reset values (clear=1, immediately and asynchronously):
  - out=0, notout=all ones, serialOut=0
  - busy=0, done=0, state IDLE, remaining=0
- clear mid-burst aborts it; no done pulse.
- Direct-mode latency: 1 edge.
- Burst of N≥1: start edge, then N shift edges; busy high for N cycles; done rises on the N-th shift edge.
- Total start-to-done: N+1 edges.
- notout and serialOut are combinational from the register and mode/burstMode.

## Configuration
- SHIFTREG_ROTATE_EN defined: modes 100/101 rotate as specified, and are valid for bursts.
- Not defined: modes 100/101 behave as hold, and start with them is ignored.

## Test plan
- Reset: assert clear mid-cycle -> out=0x00, notout=0xFF, busy=0, done=0 without waiting for an edge.
- Direct ops, WIDTH=8:
  - load preset=0xA5 -> out=0xA5
  - shift right with serialRight=1 -> 0xD2
  - shift left with serialLeft=0 -> 0xA4
  - hold for 3 edges -> 0xA4 unchanged
- Burst: out=0x01, mode=010, serialLeft=0, start with shiftCount=3 -> busy high 3 cycles, out=0x08, done single pulse on 3rd shift edge.
- Boundaries:
  - shiftCount=0 -> no shift, done pulse next cycle, busy never high.
  - shiftCount=10 on WIDTH=8 right shift with serialRight=1 -> out=0xFF.
- Abort: clear asserted after 2 of 5 burst shifts -> out=0, busy=0, no done.
  - A following start is accepted normally.
- Rotate, with SHIFTREG_ROTATE_EN: out=0x81, rotate right burst of 1 -> 0xC0.
- Rotate, without SHIFTREG_ROTATE_EN: same stimulus -> out stays 0x81, no busy.

Source files
------------

// File: rtl/shiftregister_universal_if.sv
`default_nettype none
// ============================================================================
// Module      : shiftregister_universal_if
// Description : Control/data bundle for the universal shift register.
//               master : drives mode, serial inputs, preset, start and
//                        shiftCount; observes the register outputs.
//               slave  : the shift register itself.
//               Signals:
//                 mode        operation select (hold/shift/load/rotate)
//                 serialRight bit entering the MSB on shift right
//                 serialLeft  bit entering the LSB on shift left
//                 preset      parallel-load data
//                 start       burst request
//                 shiftCount  number of shifts in a burst
//                 out/notout  register contents and complement
//                 serialOut   serial output bit for the active direction
//                 busy/done   burst in progress / completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface shiftregister_universal_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [2:0]       mode;
  logic             serialRight;
  logic             serialLeft;
  logic [WIDTH-1:0] preset;
  logic             start;
  logic [CNT_W-1:0] shiftCount;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] notout;
  logic             serialOut;
  logic             busy;
  logic             done;

  modport master (
    output mode, serialRight, serialLeft, preset, start, shiftCount,
    input  out, notout, serialOut, busy, done
  );

  modport slave (
    input  mode, serialRight, serialLeft, preset, start, shiftCount,
    output out, notout, serialOut, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/shiftregister_universal.sv
`default_nettype none
// ============================================================================
// Module      : shiftregister_universal
// Description : Parametrised universal shift register with hold, shift
//               right/left, parallel load and an autonomous burst
//               controller that performs shiftCount shifts and pulses done.
//               Optional rotate modes (100/101) are compiled in when the
//               macro SHIFTREG_ROTATE_EN is defined; otherwise those codes
//               act as hold and cannot start a burst.
//               Ports:
//                 clockpulse  rising-edge clock
//                 clear       asynchronous active-high reset
//                 bus         shiftregister_universal_if.slave bundle
// Revision    : 1.0 - initial release
// ============================================================================
module shiftregister_universal #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  wire logic                  clockpulse,
  input  wire logic                  clear,
  shiftregister_universal_if.slave   bus
);

  localparam logic [2:0] c_HOLD  = 3'b000;
  localparam logic [2:0] c_SHR   = 3'b001;
  localparam logic [2:0] c_SHL   = 3'b010;
  localparam logic [2:0] c_LOAD  = 3'b011;
  localparam logic [2:0] c_ROTR  = 3'b100;
  localparam logic [2:0] c_ROTL  = 3'b101;
  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic [2:0]       r_burst_mode;
  logic [CNT_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_done;

  logic             w_burst_ok;
  logic [2:0]       w_eff_mode;

  // Next register value for a given operation code.
  function automatic logic [WIDTH-1:0] f_next(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic             sr,
    input logic             sl,
    input logic [WIDTH-1:0] pre
  );
    logic [WIDTH-1:0] v;
    v = cur;
    case (m)
      c_SHR:   v = {sr, cur[WIDTH-1:1]};
      c_SHL:   v = {cur[WIDTH-2:0], sl};
      c_LOAD:  v = pre;
`ifdef SHIFTREG_ROTATE_EN
      c_ROTR:  v = {cur[0], cur[WIDTH-1:1]};
      c_ROTL:  v = {cur[WIDTH-2:0], cur[WIDTH-1]};
`endif
      default: v = cur;
    endcase
    return v;
  endfunction

  // Only shift/rotate codes may launch a burst; hold/load/unused ignore start.
  always_comb begin
    w_burst_ok = 1'b0;
    case (bus.mode)
      c_SHR, c_SHL: w_burst_ok = 1'b1;
`ifdef SHIFTREG_ROTATE_EN
      c_ROTR, c_ROTL: w_burst_ok = 1'b1;
`endif
      default: w_burst_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clockpulse or posedge clear) begin
    if (clear) begin
      r_state      <= S_IDLE;
      r_out        <= '0;
      r_burst_mode <= c_HOLD;
      r_remaining  <= c_CNT_ZERO;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && w_burst_ok) begin
            // Latch edge: no shift happens here.
            r_burst_mode <= bus.mode;
            r_remaining  <= bus.shiftCount;
            if (bus.shiftCount == c_CNT_ZERO) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_BUSY;
              r_busy  <= 1'b1;
            end
          end else begin
            r_out <= f_next(bus.mode, r_out, bus.serialRight,
                            bus.serialLeft, bus.preset);
          end
        end
        S_BUSY: begin
          // Serial inputs are sampled live; preset is irrelevant here.
          r_out       <= f_next(r_burst_mode, r_out, bus.serialRight,
                                bus.serialLeft, bus.preset);
          r_remaining <= r_remaining - c_CNT_ONE;
          if (r_remaining == c_CNT_ONE) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // serialOut follows the burst direction while busy, the live mode otherwise.
  assign w_eff_mode = (r_state == S_BUSY) ? r_burst_mode : bus.mode;

  always_comb begin
    bus.serialOut = r_out[0];
    case (w_eff_mode)
      c_SHL: bus.serialOut = r_out[WIDTH-1];
`ifdef SHIFTREG_ROTATE_EN
      c_ROTL: bus.serialOut = r_out[WIDTH-1];
`endif
      default: bus.serialOut = r_out[0];
    endcase
  end

  assign bus.out    = r_out;
  assign bus.notout = ~r_out;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shiftregister_universal.sv
`default_nettype none
// ============================================================================
// Module      : tb_shiftregister_universal
// Description : Directed self-checking bench for shiftregister_universal
//               (WIDTH=8, CNT_W=4). Covers reset, direct operations, bursts,
//               zero/oversize counts, abort by clear and rotate behaviour
//               for both settings of SHIFTREG_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shiftregister_universal;

  logic clk;
  logic clear;
  int   total;
  int   bad;

  shiftregister_universal_if #(.WIDTH(8), .CNT_W(4)) bus ();

  shiftregister_universal #(.WIDTH(8), .CNT_W(4)) dut (
    .clockpulse (clk),
    .clear      (clear),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear            = 1'b0;
    bus.mode         = 3'b000;
    bus.serialRight  = 1'b0;
    bus.serialLeft   = 1'b0;
    bus.preset       = 8'h00;
    bus.start        = 1'b0;
    bus.shiftCount   = 4'd0;

    // Asynchronous reset before any clock edge.
    #2 clear = 1'b1;
    #1;
    chk("rst_out",    32'(bus.out),       32'h00);
    chk("rst_notout", 32'(bus.notout),    32'hFF);
    chk("rst_busy",   32'(bus.busy),      32'h0);
    chk("rst_done",   32'(bus.done),      32'h0);
    chk("rst_sout",   32'(bus.serialOut), 32'h0);
    clear = 1'b0;
    tick();

    // Direct operations.
    bus.mode = 3'b011; bus.preset = 8'hA5;
    tick();
    chk("load_out",    32'(bus.out),    32'hA5);
    chk("load_notout", 32'(bus.notout), 32'h5A);

    bus.mode = 3'b001; bus.serialRight = 1'b1;
    tick();
    chk("shr_out",  32'(bus.out),       32'hD2);
    chk("shr_sout", 32'(bus.serialOut), 32'h0);

    bus.mode = 3'b010; bus.serialLeft = 1'b0;
    tick();
    chk("shl_out",  32'(bus.out),       32'hA4);
    chk("shl_sout", 32'(bus.serialOut), 32'h1);

    bus.mode = 3'b000;
    tick(); tick(); tick();
    chk("hold_out", 32'(bus.out), 32'hA4);

    // Burst of 3 left shifts from 0x01.
    bus.mode = 3'b011; bus.preset = 8'h01;
    tick();
    bus.mode = 3'b010; bus.serialLeft = 1'b0; bus.start = 1'b1; bus.shiftCount = 4'd3;
    tick();
    chk("b3_latch_out",  32'(bus.out),  32'h01);
    chk("b3_latch_busy", 32'(bus.busy), 32'h1);
    chk("b3_latch_done", 32'(bus.done), 32'h0);
    // Inputs below must be ignored while busy.
    bus.start = 1'b0; bus.mode = 3'b011; bus.preset = 8'hFF;
    tick();
    chk("b3_s1_out",  32'(bus.out),  32'h02);
    chk("b3_s1_busy", 32'(bus.busy), 32'h1);
    tick();
    chk("b3_s2_out",  32'(bus.out),  32'h04);
    chk("b3_s2_done", 32'(bus.done), 32'h0);
    bus.mode = 3'b000;
    tick();
    chk("b3_s3_out",  32'(bus.out),  32'h08);
    chk("b3_s3_busy", 32'(bus.busy), 32'h0);
    chk("b3_s3_done", 32'(bus.done), 32'h1);
    tick();
    chk("b3_after_done", 32'(bus.done), 32'h0);
    chk("b3_after_out",  32'(bus.out),  32'h08);

    // Zero-length burst.
    bus.mode = 3'b001; bus.serialRight = 1'b1; bus.start = 1'b1; bus.shiftCount = 4'd0;
    tick();
    chk("b0_out",  32'(bus.out),  32'h08);
    chk("b0_busy", 32'(bus.busy), 32'h0);
    chk("b0_done", 32'(bus.done), 32'h1);
    bus.start = 1'b0; bus.mode = 3'b000;
    tick();
    chk("b0_done_clr", 32'(bus.done), 32'h0);
    chk("b0_busy_clr", 32'(bus.busy), 32'h0);

    // Oversize burst: 10 right shifts filling with ones.
    bus.mode = 3'b001; bus.serialRight = 1'b1; bus.start = 1'b1; bus.shiftCount = 4'd10;
    tick();
    chk("b10_latch_busy", 32'(bus.busy), 32'h1);
    bus.start = 1'b0; bus.mode = 3'b000;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("b10_busy", 32'(bus.busy), 32'h1);
    end
    tick();
    chk("b10_out",  32'(bus.out),  32'hFF);
    chk("b10_busy_end", 32'(bus.busy), 32'h0);
    chk("b10_done", 32'(bus.done), 32'h1);

    // Abort a 5-shift burst after 2 shifts.
    bus.mode = 3'b001; bus.serialRight = 1'b0; bus.start = 1'b1; bus.shiftCount = 4'd5;
    tick();
    bus.start = 1'b0; bus.mode = 3'b000;
    tick(); tick();
    chk("abort_pre_out", 32'(bus.out), 32'h3F);
    #2 clear = 1'b1;
    #1;
    chk("abort_out",  32'(bus.out),  32'h00);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_done", 32'(bus.done), 32'h0);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", 32'(bus.done), 32'h0);
      chk("abort_no_busy", 32'(bus.busy), 32'h0);
    end
    bus.mode = 3'b010; bus.serialLeft = 1'b1; bus.start = 1'b1; bus.shiftCount = 4'd2;
    tick();
    chk("restart_busy", 32'(bus.busy), 32'h1);
    bus.start = 1'b0; bus.mode = 3'b000;
    tick();
    chk("restart_s1", 32'(bus.out), 32'h01);
    tick();
    chk("restart_s2",   32'(bus.out),  32'h03);
    chk("restart_done", 32'(bus.done), 32'h1);

    // Rotate right burst of 1 from 0x81.
    bus.mode = 3'b011; bus.preset = 8'h81;
    tick();
    bus.mode = 3'b100; bus.start = 1'b1; bus.shiftCount = 4'd1;
    tick();
`ifdef SHIFTREG_ROTATE_EN
    chk("rot_latch_busy", 32'(bus.busy), 32'h1);
    chk("rot_latch_out",  32'(bus.out),  32'h81);
`else
    chk("rot_off_busy", 32'(bus.busy), 32'h0);
    chk("rot_off_out",  32'(bus.out),  32'h81);
`endif
    bus.start = 1'b0; bus.mode = 3'b000;
    tick();
`ifdef SHIFTREG_ROTATE_EN
    chk("rot_out",  32'(bus.out),  32'hC0);
    chk("rot_done", 32'(bus.done), 32'h1);
    chk("rot_busy", 32'(bus.busy), 32'h0);
`else
    chk("rot_off_out2",  32'(bus.out),  32'h81);
    chk("rot_off_done",  32'(bus.done), 32'h0);
    chk("rot_off_busy2", 32'(bus.busy), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
